reg_file_mp: RTL and testbench

- Parametrised multi-port successor of the single-write, dual-read register file used by the CPU datapath.
- Adds N read / M write ports, byte-strobed writes, optional same-cycle write-to-read bypass, and a per-register busy scoreboard so a pipelined core can detect pending writers.
- Register 0 stays hardwired to zero. The block sits between decode (reads, reservations) and writeback (writes, busy release).

---
 rtl/regfile_pkg.sv | 13 +
 rtl/reg_file_mp_if.sv | 31 +++
 rtl/reg_scoreboard.sv | 61 ++++++
 rtl/reg_file_mp.sv | 80 ++++++++
 tb/tb_reg_file_mp.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and packed-port slicing helper for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned STRB_WIDTH     = DATA_WIDTH_DEF / 8;

  // Low bit of port 'idx' inside a packed vector of 'width'-bit slices.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Read, write and reservation bus between decode/writeback and the register file.
interface reg_file_mp_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_RPORTS = 2,
  parameter int unsigned NUM_WPORTS = 2
);
  localparam int unsigned SW = DATA_WIDTH / 8;

  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr;
  logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata;
  logic [NUM_RPORTS-1:0]            rbusy;
  logic [NUM_WPORTS-1:0]            wen;
  logic [NUM_WPORTS*ADDR_WIDTH-1:0] waddr;
  logic [NUM_WPORTS*SW-1:0]         wstrb;
  logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata;
  logic [NUM_WPORTS-1:0]            wclr;
  logic                             rsv_en;
  logic [ADDR_WIDTH-1:0]            rsv_addr;
  logic [ADDR_WIDTH:0]              busy_cnt;

  modport master (
    output raddr, wen, waddr, wstrb, wdata, wclr, rsv_en, rsv_addr,
    input  rdata, rbusy, busy_cnt
  );

  modport slave (
    input  raddr, wen, waddr, wstrb, wdata, wclr, rsv_en, rsv_addr,
    output rdata, rbusy, busy_cnt
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits with reserve-over-clear priority and an incremental busy count.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned NUM_WPORTS = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_WPORTS-1:0]            i_wen,
  input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] i_waddr,
  input  logic [NUM_WPORTS-1:0]            i_wclr,
  input  logic                             i_rsv_en,
  input  logic [ADDR_WIDTH-1:0]            i_rsv_addr,
  output logic [2**ADDR_WIDTH-1:0]         o_busy,
  output logic [ADDR_WIDTH:0]              o_busy_cnt
);
  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0]      r_busy;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [DEPTH-1:0]      w_set, w_clr, w_rise, w_fall;
  logic [ADDR_WIDTH-1:0] w_waddr [NUM_WPORTS];
  logic [ADDR_WIDTH:0]   w_inc, w_dec;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int unsigned j = 0; j < NUM_WPORTS; j++) begin
      w_waddr[j] = i_waddr[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH];
      if (i_wen[j] && i_wclr[j] && (w_waddr[j] != '0))
        w_clr[w_waddr[j]] = 1'b1;
    end
    if (i_rsv_en && (i_rsv_addr != '0))
      w_set[i_rsv_addr] = 1'b1;
  end

  // Reserve wins over clear, so only clears not overridden by a set can fall.
  assign w_rise = w_set & ~r_busy;
  assign w_fall = r_busy & w_clr & ~w_set;
  assign w_inc  = {{ADDR_WIDTH{1'b0}}, |w_rise};

  always_comb begin
    w_dec = '0;
    for (int unsigned k = 0; k < DEPTH; k++)
      w_dec = w_dec + {{ADDR_WIDTH{1'b0}}, w_fall[k]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      r_cnt  <= r_cnt + w_inc - w_dec;
    end
  end

  assign o_busy     = r_busy;
  assign o_busy_cnt = r_cnt;
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: byte-strobed writes, optional write-to-read bypass, busy scoreboard.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned NUM_RPORTS = 2,
  parameter int unsigned NUM_WPORTS = 2,
  parameter int unsigned BYPASS     = 1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);
  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam int unsigned SW    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem   [DEPTH];
  logic [DEPTH-1:0]      w_busy;
  logic [ADDR_WIDTH-1:0] w_waddr [NUM_WPORTS];
  logic [SW-1:0]         w_wstrb [NUM_WPORTS];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_WPORTS];
  logic [ADDR_WIDTH-1:0] w_raddr [NUM_RPORTS];
  logic [DATA_WIDTH-1:0] w_rdata [NUM_RPORTS];

  always_comb begin
    for (int unsigned j = 0; j < NUM_WPORTS; j++) begin
      w_waddr[j] = bus.waddr[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH];
      w_wstrb[j] = bus.wstrb[slice_lo(j, SW) +: SW];
      w_wdata[j] = bus.wdata[slice_lo(j, DATA_WIDTH) +: DATA_WIDTH];
    end
  end

  // Later ports overwrite earlier ones per byte, giving higher-port priority on conflicts.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++)
        r_mem[k] <= '0;
    end else begin
      for (int unsigned j = 0; j < NUM_WPORTS; j++)
        for (int unsigned b = 0; b < SW; b++)
          if (bus.wen[j] && (w_waddr[j] != '0) && w_wstrb[j][b])
            r_mem[w_waddr[j]][b*8 +: 8] <= w_wdata[j][b*8 +: 8];
    end
  end

  always_comb begin
    bus.rdata = '0;
    bus.rbusy = '0;
    for (int unsigned i = 0; i < NUM_RPORTS; i++) begin
      w_raddr[i] = bus.raddr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
      w_rdata[i] = r_mem[w_raddr[i]];
      if (BYPASS != 0) begin
        for (int unsigned j = 0; j < NUM_WPORTS; j++)
          for (int unsigned b = 0; b < SW; b++)
            if (bus.wen[j] && (w_waddr[j] != '0) && (w_waddr[j] == w_raddr[i]) && w_wstrb[j][b])
              w_rdata[i][b*8 +: 8] = w_wdata[j][b*8 +: 8];
      end
      if (w_raddr[i] == '0)
        w_rdata[i] = '0;
      bus.rdata[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] = w_rdata[i];
      bus.rbusy[i] = (w_raddr[i] != '0) && w_busy[w_raddr[i]];
    end
  end

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WPORTS (NUM_WPORTS)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_wen      (bus.wen),
    .i_waddr    (bus.waddr),
    .i_wclr     (bus.wclr),
    .i_rsv_en   (bus.rsv_en),
    .i_rsv_addr (bus.rsv_addr),
    .o_busy     (w_busy),
    .o_busy_cnt (bus.busy_cnt)
  );
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one bypassing and one non-bypassing instance share stimulus.
module tb_reg_file_mp;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RPORTS(2), .NUM_WPORTS(2)) bus0 ();
  reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RPORTS(2), .NUM_WPORTS(2)) bus1 ();

  assign bus1.raddr    = bus0.raddr;
  assign bus1.wen      = bus0.wen;
  assign bus1.waddr    = bus0.waddr;
  assign bus1.wstrb    = bus0.wstrb;
  assign bus1.wdata    = bus0.wdata;
  assign bus1.wclr     = bus0.wclr;
  assign bus1.rsv_en   = bus0.rsv_en;
  assign bus1.rsv_addr = bus0.rsv_addr;

  reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RPORTS(2), .NUM_WPORTS(2), .BYPASS(1))
    u_dut_byp (.clk(clk), .rst(rst), .bus(bus0));
  reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RPORTS(2), .NUM_WPORTS(2), .BYPASS(0))
    u_dut_nob (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus0.wen      = '0;
    bus0.waddr    = '0;
    bus0.wstrb    = '0;
    bus0.wdata    = '0;
    bus0.wclr     = '0;
    bus0.rsv_en   = 1'b0;
    bus0.rsv_addr = '0;
  endtask

  initial begin
    rst        = 1'b1;
    bus0.raddr = '0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state on every register and both read ports
    for (int a = 0; a < 32; a++) begin
      bus0.raddr = {5'(31 - a), 5'(a)};
      #1;
      check("rst_rdata0", bus0.rdata[31:0], 32'h0);
      check("rst_rdata1", bus0.rdata[63:32], 32'h0);
      check("rst_rbusy", 32'(bus0.rbusy), 32'h0);
    end
    check("rst_cnt", 32'(bus0.busy_cnt), 32'h0);

    // Full write then byte-strobed partial write of r5
    bus0.wen = 2'b01; bus0.waddr = {5'd0, 5'd5};
    bus0.wstrb = {4'h0, 4'hF}; bus0.wdata = {32'h0, 32'hDEADBEEF};
    tick();
    bus0.wstrb = {4'h0, 4'h2}; bus0.wdata = {32'h0, 32'h00001100};
    bus0.raddr = {5'd0, 5'd5};
    #1;
    check("r5_byp_same", bus0.rdata[31:0], 32'hDEAD11EF);
    check("r5_nob_same", bus1.rdata[31:0], 32'hDEADBEEF);
    tick();
    idle();
    #1;
    check("r5_byp_after", bus0.rdata[31:0], 32'hDEAD11EF);
    check("r5_nob_after", bus1.rdata[31:0], 32'hDEAD11EF);

    // Zero strobe leaves data unchanged
    bus0.wen = 2'b01; bus0.waddr = {5'd0, 5'd5};
    bus0.wstrb = '0; bus0.wdata = {32'h0, 32'h55555555};
    tick();
    idle();
    #1;
    check("r5_strb0", bus0.rdata[31:0], 32'hDEAD11EF);

    // Both ports write r7: higher port wins
    bus0.wen = 2'b11; bus0.waddr = {5'd7, 5'd7};
    bus0.wstrb = {4'hF, 4'hF}; bus0.wdata = {32'h22222222, 32'h11111111};
    bus0.raddr = {5'd5, 5'd7};
    #1;
    check("r7_byp_same", bus0.rdata[31:0], 32'h22222222);
    check("r7_nob_same", bus1.rdata[31:0], 32'h0);
    tick();
    idle();
    #1;
    check("r7_after", bus0.rdata[31:0], 32'h22222222);
    check("r7_nob_after", bus1.rdata[31:0], 32'h22222222);
    check("r5_port1", bus0.rdata[63:32], 32'hDEAD11EF);

    // Register 0 ignores writes and reservations
    bus0.wen = 2'b01; bus0.waddr = '0;
    bus0.wstrb = {4'h0, 4'hF}; bus0.wdata = {32'h0, 32'hFFFFFFFF};
    bus0.rsv_en = 1'b1; bus0.rsv_addr = 5'd0;
    bus0.raddr = '0;
    #1;
    check("r0_byp_same", bus0.rdata[31:0], 32'h0);
    tick();
    idle();
    #1;
    check("r0_after", bus0.rdata[31:0], 32'h0);
    check("r0_rbusy", 32'(bus0.rbusy), 32'h0);
    check("r0_cnt", 32'(bus0.busy_cnt), 32'h0);

    // Scoreboard: reserve r3, r9; reserve+clear r3; clear both
    bus0.rsv_en = 1'b1; bus0.rsv_addr = 5'd3;
    bus0.raddr = {5'd9, 5'd3};
    #1;
    check("rbusy_not_same_cycle", 32'(bus0.rbusy), 32'h0);
    tick();
    check("cnt_r3", 32'(bus0.busy_cnt), 32'd1);
    bus0.rsv_addr = 5'd9;
    tick();
    check("cnt_r9", 32'(bus0.busy_cnt), 32'd2);
    check("rbusy_r3_r9", 32'(bus0.rbusy), 32'h3);
    bus0.rsv_addr = 5'd3;
    bus0.wen = 2'b01; bus0.waddr = {5'd0, 5'd3}; bus0.wclr = 2'b01; bus0.wstrb = '0;
    tick();
    check("cnt_rsv_wins", 32'(bus0.busy_cnt), 32'd2);
    check("rbusy_rsv_wins", 32'(bus0.rbusy), 32'h3);
    bus0.rsv_en = 1'b0;
    bus0.wen = 2'b11; bus0.waddr = {5'd9, 5'd3}; bus0.wclr = 2'b11;
    #1;
    check("rbusy_pre_clear", 32'(bus0.rbusy), 32'h3);
    tick();
    idle();
    #1;
    check("cnt_cleared", 32'(bus0.busy_cnt), 32'd0);
    check("rbusy_cleared", 32'(bus0.rbusy), 32'h0);

    // Clear of non-busy register has no effect
    bus0.wen = 2'b01; bus0.waddr = {5'd0, 5'd3}; bus0.wclr = 2'b01;
    tick();
    idle();
    check("cnt_clr_idle", 32'(bus0.busy_cnt), 32'd0);

    // Reset mid-operation discards writes and reservations
    bus0.wen = 2'b01; bus0.waddr = {5'd0, 5'd4};
    bus0.wstrb = {4'h0, 4'hF}; bus0.wdata = {32'h0, 32'h00001234};
    bus0.rsv_en = 1'b1; bus0.rsv_addr = 5'd4;
    tick();
    idle();
    bus0.raddr = {5'd5, 5'd4};
    #1;
    check("r4_pre", bus0.rdata[31:0], 32'h00001234);
    check("r4_busy_pre", 32'(bus0.rbusy), 32'h1);
    check("cnt_pre", 32'(bus0.busy_cnt), 32'd1);
    rst = 1'b1;
    bus0.wen = 2'b01; bus0.waddr = {5'd0, 5'd4};
    bus0.wstrb = {4'h0, 4'hF}; bus0.wdata = {32'h0, 32'hFFFFFFFF};
    bus0.rsv_en = 1'b1; bus0.rsv_addr = 5'd6;
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("r4_rst", bus0.rdata[31:0], 32'h0);
    check("r5_rst", bus0.rdata[63:32], 32'h0);
    check("rbusy_rst", 32'(bus0.rbusy), 32'h0);
    check("cnt_rst", 32'(bus0.busy_cnt), 32'd0);
    bus0.raddr = {5'd7, 5'd6};
    #1;
    check("r6_busy_rst", 32'(bus0.rbusy), 32'h0);
    check("r7_rst", bus0.rdata[63:32], 32'h0);
    tick();
    check("cnt_rst_hold", 32'(bus0.busy_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
